// File: rtl/bch_encoder.sv
// Systematic BCH(8191,8087,t=8) encoder over GF(2^13). It takes 32 bits per clock and emits 256-word frames.
// Optional build macro BCH_ENC_ERR_INJ_EN adds an err_mask input that is XORed onto dout only.

package bch_encoder_pkg;

    function automatic logic [12:0] gf13_mul(input logic [12:0] a, input logic [12:0] b);
        logic [12:0] acc;
        logic [12:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 13; i++) begin
            if (b[4'(i)]) acc = acc ^ sh;
            sh = sh[12] ? ({sh[11:0], 1'b0} ^ 13'h001B) : {sh[11:0], 1'b0};
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^r) over the cyclotomic cosets of 1,3,..,15; all coefficients land in GF(2).
    function automatic logic [103:0] bch_gen_poly();
        logic [104:0][12:0] c;
        logic [12:0]        root;
        logic [103:0]       g;
        int                 deg;
        c    = '0;
        c[0] = 13'h1;
        deg  = 0;
        g    = '0;
        for (int k = 1; k < 16; k += 2) begin
            root = 13'h1;
            for (int j = 0; j < k; j++) root = gf13_mul(root, 13'h2);
            for (int s = 0; s < 13; s++) begin
                for (int i = deg + 1; i > 0; i--)
                    c[7'(i)] = c[7'(i - 1)] ^ gf13_mul(c[7'(i)], root);
                c[0] = gf13_mul(c[0], root);
                deg++;
                root = gf13_mul(root, root);
            end
        end
        for (int i = 0; i < 104; i++) g[7'(i)] = c[7'(i)][0];
        return g;
    endfunction

endpackage

// Handshake: a word moves on a rising edge when din_valid && din_ready. The producer holds din stable
// until it is accepted. The output side has no backpressure: each dout_valid pulse is one word.
module bch_encoder
    import bch_encoder_pkg::*;
#(
    parameter int                    CODE_LENGTH     = 8191,
    parameter int                    CHECK_BITS      = 104,
    parameter int                    PARALLEL_FACTOR = 32,
    parameter logic [CHECK_BITS-1:0] GEN_POLY        = bch_gen_poly()
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PARALLEL_FACTOR-1:0] din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [PARALLEL_FACTOR-1:0] dout,
    output logic                       dout_valid,
    output logic                       dout_sof,
    output logic                       dout_eof,
`ifdef BCH_ENC_ERR_INJ_EN
    input  logic [PARALLEL_FACTOR-1:0] err_mask,
`endif
    output logic [1:0]                 dbg_state
);

    localparam int W         = PARALLEL_FACTOR;
    localparam int R         = CHECK_BITS;
    localparam int NWORDS    = (CODE_LENGTH + 1) / W;
    localparam int PAR_WORDS = R / W;
    localparam int MIX_BITS  = R % W;
    localparam int MIX_WORD  = NWORDS - PAR_WORDS - 1;
    localparam int LAST_WORD = NWORDS - 1;
    localparam int CW        = $clog2(NWORDS);

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_MIX  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wcnt;
    logic [R-1:0]   rem_q, lfsr_next;
    logic [W-1:0]   din_eff, dout_next;
    logic           fb, xfer, step;

    assign xfer = din_valid && din_ready;
    assign step = xfer || (state_q == ST_PAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_DATA;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DATA: if (xfer && wcnt == CW'(MIX_WORD - 1)) state_d = ST_MIX;
            ST_MIX:  if (xfer) state_d = ST_PAR;
            ST_PAR:  if (wcnt == CW'(LAST_WORD)) state_d = ST_DATA;
            default: state_d = ST_DATA;
        endcase
    end

    always_comb begin
        din_ready = reset && (state_q != ST_PAR);
        dbg_state = state_q;
    end

    // Bit-serial division unrolled across the word. In MIX only the top W-MIX_BITS bits are message.
    always_comb begin
        din_eff = din;
        if (wcnt == '0) din_eff[W-1] = 1'b0;
        lfsr_next = rem_q;
        fb        = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (state_q != ST_MIX || i >= MIX_BITS) begin
                fb        = lfsr_next[R-1] ^ din_eff[i];
                lfsr_next = {lfsr_next[R-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
            end
        end
    end

    always_comb begin
        dout_next = din_eff;
        case (state_q)
            ST_MIX: dout_next = {din_eff[W-1:MIX_BITS], lfsr_next[R-1 -: MIX_BITS]};
            ST_PAR: begin
                for (int k = 0; k < PAR_WORDS; k++)
                    if (wcnt == CW'(MIX_WORD + 1 + k))
                        dout_next = rem_q[(PAR_WORDS - 1 - k) * W +: W];
            end
            default: ;
        endcase
`ifdef BCH_ENC_ERR_INJ_EN
        dout_next = dout_next ^ err_mask;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt       <= '0;
            rem_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
        end else begin
            dout_valid <= step;
            dout_sof   <= step && (wcnt == '0);
            dout_eof   <= step && (wcnt == CW'(LAST_WORD));
            if (step) begin
                wcnt <= wcnt + 1'b1;
                dout <= dout_next;
            end
            if (xfer) rem_q <= lfsr_next;
            else if (state_q == ST_PAR && wcnt == CW'(LAST_WORD)) rem_q <= '0;
        end
    end

endmodule

// File: doc/bch_encoder.md
BCH_ENCODER -- requirements
Module: bch_encoder

Interface
REQ-001 Parameter CODE_LENGTH, default 8191, meaning: codeword length n in bits.
REQ-002 Parameter CHECK_BITS, default 104, meaning: parity bits (t=8, m=13).
REQ-003 Parameter PARALLEL_FACTOR, default 32, meaning: bits per clock.
REQ-004 Parameter GEN_POLY, default g(x) = LCM of minimal polynomials of alpha^1..alpha^16 over GF(2^13), p(x)=x^13+x^4+x^3+x+1, meaning: coefficients x^103..x^0, x^104 implicit.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 din  input  32  message word; bit 31 earliest in time.
REQ-008 din_valid  input  1  din holds a message word.
REQ-009 din_ready  output  1  encoder accepts din this cycle.
REQ-010 dout  output  32  codeword word; bit 31 earliest; frame bit 0 is a zero pad.
REQ-011 dout_valid  output  1  dout holds a codeword word.
REQ-012 dout_sof  output  1  high with frame word 0.
REQ-013 dout_eof  output  1  high with frame word 255.

Function
REQ-014 Frame SHALL be 256 words (8192 bits): 1 pad bit + 8087 info bits + 104 parity bits; word w bit b carries coefficient of x^(8191-32w-(31-b)).
REQ-015 Transfer SHALL occur when din_valid and din_ready are both high on a rising edge; a 8-bit word counter wcnt (0..255) SHALL advance once per input transfer or parity cycle.
REQ-016 States: DATA (wcnt 0..251), MIX (wcnt 252), PAR (wcnt 253..255); DATA->MIX after word 251 accepted, MIX->PAR after word 252 accepted, PAR->DATA after word 255 emitted, wcnt wraps to 0.
REQ-017 din_ready SHALL be high in DATA and MIX, low in PAR.
REQ-018 In word 0, din[31] SHALL be forced to 0 on both dout and the LFSR input.
REQ-019 DATA: 104-bit LFSR remainder SHALL absorb 32 bits per transfer (parallel division by g(x)), dout = din.
REQ-020 MIX: only din[31:8] (24 bits) SHALL be absorbed; din[7:0] ignored; dout = {din[31:8], new_rem[103:96]}.
REQ-021 PAR: dout SHALL be new_rem[95:64], [63:32], [31:0] on successive cycles, no absorption; LFSR SHALL clear to 0 after the last parity word.
REQ-022 Output latency SHALL be exactly 1 cycle (registered dout/flags); dout_valid high the cycle after each transfer and on each PAR cycle.
REQ-023 din_valid low in DATA/MIX SHALL hold LFSR, wcnt and state; dout_valid low that cycle; no timeout.
REQ-024 Output has no backpressure; sink always accepts.
REQ-025 Back-to-back frames SHALL be supported: word 0 of next frame accepted the cycle after PAR ends, 3-cycle gap per frame.

Reset
REQ-026 On reset low, asynchronously: state=DATA, wcnt=0, LFSR=0, dout=0, dout_valid=0, dout_sof=0, dout_eof=0; din_ready=0 while reset low.
REQ-027 Reset mid-frame SHALL discard the partial frame; first transfer after release is word 0.

Configuration
REQ-028 Macro BCH_ENC_ERR_INJ_EN defined: input err_mask[31:0] added, XORed onto dout after parity computation (affects output only, not LFSR).
REQ-029 Macro undefined: port absent, dout is the clean codeword.

Verification
REQ-030 All-zero message, 253 words -> 256 words all 32'h0, sof on word 0, eof on word 255.
REQ-031 Only word 252 = 32'h00000100 (coefficient x^104) -> words 252..255 = {24'h000001, GEN_POLY[103:96]}, GEN_POLY[95:64], [63:32], [31:0].
REQ-032 Word 0 = 32'h80000000, rest zero -> dout word 0 = 32'h0, all parity zero.
REQ-033 Random 8087-bit message with random din_valid gaps -> codeword fed to syndrome block gives S1..S16 all 13'h0; repeat with one bit of err_mask set (macro on) -> S1 nonzero.
REQ-034 Reset asserted at wcnt=100 then full zero frame -> output identical to REQ-030, no residual parity.
REQ-035 Two back-to-back random frames -> din_ready low exactly 3 cycles between frames, both codewords match reference model.
